// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes and debounces two pushbuttons and the switches, producing one-cycle command pulses.
// Ports: Clk/Reset (async, active-high); ClearA_LoadB_n, Execute_n, Switches raw async inputs; Busy from the multiplier;
// ClearA_LoadB_P and Execute_P single-cycle pulses; Exec_Pending deferred execute; Operand captured switches; Switches_S synced switches.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ClearA_LoadB_n,
  input  logic       Execute_n,
  input  logic [7:0] Switches,
  input  logic       Busy,
  output logic       ClearA_LoadB_P,
  output logic       Execute_P,
  output logic       Exec_Pending,
  output logic [7:0] Operand,
  output logic [7:0] Switches_S
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] FULL = CW'(DEBOUNCE_CYCLES);
  typedef enum logic [1:0] {RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK} db_state_e;
  logic [1:0] btn_m_q, btn_s_q, lvl, acc;
  logic [7:0] sw_m_q, sw_s_q, operand_q;
  logic       clr_p_q, exe_p_q, pend_q;
  logic       exe_p_d, pend_d;
  // bit 0 = ClearA_LoadB, bit 1 = Execute; buttons idle high
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      btn_m_q <= 2'b11;
      btn_s_q <= 2'b11;
      sw_m_q  <= '0;
      sw_s_q  <= '0;
    end else begin
      btn_m_q <= {Execute_n, ClearA_LoadB_n};
      btn_s_q <= btn_m_q;
      sw_m_q  <= Switches;
      sw_s_q  <= sw_m_q;
    end
  assign lvl = ~btn_s_q;
  for (genvar b = 0; b < 2; b++) begin : g_db
    db_state_e     st_q;
    logic [CW-1:0] cnt_q;
    logic          acc_q;
    // acc_q marks the edge the FSM entered PRESSED; the output stage registers it once more
    always_ff @(posedge Clk or posedge Reset)
      if (Reset) begin
        st_q  <= RELEASED;
        cnt_q <= '0;
        acc_q <= 1'b0;
      end else begin
        acc_q <= 1'b0;
        case (st_q)
          RELEASED:
            if (lvl[b]) begin
              st_q  <= PRESS_CHK;
              cnt_q <= CW'(1);
            end
          PRESS_CHK:
            if (!lvl[b]) begin
              st_q  <= RELEASED;
              cnt_q <= '0;
            end else if (cnt_q == LAST) begin
              st_q  <= PRESSED;
              cnt_q <= '0;
              acc_q <= 1'b1;
            end else cnt_q <= (cnt_q == FULL) ? cnt_q : cnt_q + CW'(1);
          PRESSED:
            if (!lvl[b]) begin
              st_q  <= RELEASE_CHK;
              cnt_q <= CW'(1);
            end
          RELEASE_CHK:
            if (lvl[b]) begin
              st_q  <= PRESSED;
              cnt_q <= '0;
            end else if (cnt_q == LAST) begin
              st_q  <= RELEASED;
              cnt_q <= '0;
            end else cnt_q <= (cnt_q == FULL) ? cnt_q : cnt_q + CW'(1);
          default: begin
            st_q  <= RELEASED;
            cnt_q <= '0;
          end
        endcase
      end
    assign acc[b] = acc_q;
  end
  // a press while a request is already pending is dropped
  always_comb begin
    exe_p_d = ~Busy & (pend_q | acc[1]);
    pend_d  = pend_q ? Busy : (acc[1] & Busy);
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      clr_p_q   <= 1'b0;
      exe_p_q   <= 1'b0;
      pend_q    <= 1'b0;
      operand_q <= '0;
    end else begin
      clr_p_q   <= acc[0];
      exe_p_q   <= exe_p_d;
      pend_q    <= pend_d;
      operand_q <= acc[0] ? sw_s_q : operand_q;
    end
  assign ClearA_LoadB_P = clr_p_q;
  assign Execute_P      = exe_p_q;
  assign Exec_Pending   = pend_q;
  assign Operand        = operand_q;
  assign Switches_S     = sw_s_q;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: scoreboard bench; stimulus queues expected pulses, a negedge monitor checks them.
module tb_input_conditioner;
  logic       Clk = 1'b0, Reset = 1'b1, clr_n = 1'b1, exe_n = 1'b1, Busy = 1'b0;
  logic [7:0] sw = 8'h00;
  logic       clr_p, exe_p, pend;
  logic [7:0] operand, sw_s;
  input_conditioner #(.DEBOUNCE_CYCLES(16)) dut (
    .Clk(Clk), .Reset(Reset), .ClearA_LoadB_n(clr_n), .Execute_n(exe_n), .Switches(sw), .Busy(Busy),
    .ClearA_LoadB_P(clr_p), .Execute_P(exe_p), .Exec_Pending(pend), .Operand(operand), .Switches_S(sw_s)
  );
  always #5 Clk = ~Clk;
  int cyc = 0;
  always @(posedge Clk) cyc++;
  typedef struct {int cyc; logic clr; logic exe; logic [7:0] op;} exp_t;
  exp_t q[$];
  exp_t mon_e;
  int compared = 0, mismatched = 0;
  logic [7:0] exp_op = 8'h00;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask
  task automatic push(input int dly, input logic c, input logic e);
    exp_t x;
    x.cyc = cyc + dly; x.clr = c; x.exe = e; x.op = exp_op;
    q.push_back(x);
  endtask
  task automatic cycles(input int n);
    repeat (n) @(negedge Clk);
  endtask
  always @(negedge Clk)
    if (!Reset && (clr_p || exe_p)) begin
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_pulse: got clr=%b exe=%b at cycle %0d want none", clr_p, exe_p, cyc);
      end else begin
        mon_e = q.pop_front();
        chk("pulse_cycle", cyc, mon_e.cyc);
        chk("pulse_clr", {31'b0, clr_p}, {31'b0, mon_e.clr});
        chk("pulse_exe", {31'b0, exe_p}, {31'b0, mon_e.exe});
        chk("pulse_operand", {24'b0, operand}, {24'b0, mon_e.op});
      end
    end
  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
  initial begin
    sw = 8'hFF;
    cycles(3);
    chk("rst_clr_p", {31'b0, clr_p}, 0);
    chk("rst_exe_p", {31'b0, exe_p}, 0);
    chk("rst_pend", {31'b0, pend}, 0);
    chk("rst_operand", {24'b0, operand}, 0);
    chk("rst_sw_s", {24'b0, sw_s}, 0);
    Reset = 1'b0; sw = 8'h00;
    cycles(5);
    exe_n = 1'b0; push(19, 1'b0, 1'b1);
    cycles(60);
    exe_n = 1'b1;
    cycles(30);
    for (int i = 0; i < 10; i++) begin
      exe_n = i[0];
      cycles(3);
    end
    exe_n = 1'b0; push(19, 1'b0, 1'b1);
    cycles(40);
    exe_n = 1'b1;
    cycles(30);
    sw = 8'hA5;
    cycles(4);
    clr_n = 1'b0; exp_op = 8'hA5; push(19, 1'b1, 1'b0);
    cycles(25);
    sw = 8'h3C;
    cycles(10);
    chk("operand_hold", {24'b0, operand}, 32'hA5);
    chk("sw_s_follow", {24'b0, sw_s}, 32'h3C);
    clr_n = 1'b1;
    cycles(30);
    Busy = 1'b1; exe_n = 1'b0;
    cycles(19);
    chk("pend_set", {31'b0, pend}, 1);
    cycles(10);
    exe_n = 1'b1;
    cycles(30);
    exe_n = 1'b0;
    cycles(25);
    exe_n = 1'b1;
    cycles(15);
    chk("pend_held", {31'b0, pend}, 1);
    Busy = 1'b0; push(1, 1'b0, 1'b1);
    cycles(1);
    chk("pend_clear", {31'b0, pend}, 0);
    cycles(10);
    sw = 8'h5A;
    cycles(4);
    clr_n = 1'b0; exe_n = 1'b0; exp_op = 8'h5A; push(19, 1'b1, 1'b1);
    cycles(30);
    clr_n = 1'b1; exe_n = 1'b1;
    cycles(30);
    Busy = 1'b1; exe_n = 1'b0;
    cycles(25);
    exe_n = 1'b1;
    cycles(30);
    chk("pend_before_rst", {31'b0, pend}, 1);
    clr_n = 1'b0;
    cycles(12);
    Reset = 1'b1; clr_n = 1'b1; exp_op = 8'h00;
    #1;
    chk("midrst_clr_p", {31'b0, clr_p}, 0);
    chk("midrst_exe_p", {31'b0, exe_p}, 0);
    chk("midrst_pend", {31'b0, pend}, 0);
    chk("midrst_operand", {24'b0, operand}, 0);
    cycles(2);
    Reset = 1'b0; Busy = 1'b0;
    cycles(40);
    chk("post_rst_pend", {31'b0, pend}, 0);
    Reset = 1'b1; exe_n = 1'b0;
    cycles(3);
    Reset = 1'b0; push(19, 1'b0, 1'b1);
    cycles(40);
    exe_n = 1'b1;
    cycles(30);
    while (q.size() > 0) begin
      mon_e = q.pop_front();
      compared++;
      mismatched++;
      $display("FAIL missing_pulse: got none want clr=%b exe=%b at cycle %0d", mon_e.clr, mon_e.exe, mon_e.cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
